// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, fetch FSM encoding, word widths.
package instr_fetch_unit_pkg;

    localparam int INS_W  = 16;
    localparam int DISP_W = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_BRZ  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [INS_W-1:0] word);
        return word[INS_W-1 -: 4];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if #(parameter int PC_W = 8);
    import instr_fetch_unit_pkg::*;

    logic             req;
    logic [PC_W-1:0]  addr;
    logic             valid;
    logic [INS_W-1:0] rdata;

    modport master (output req, output addr, input valid, input rdata);
    modport slave  (input req, input addr, output valid, output rdata);

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC selection: sequential pc+1, or pc+1 plus the sign-extended branch displacement.
module pc_next_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]   pc,
    input  logic              jump,
    input  logic [DISP_W-1:0] disp,
    output logic [PC_W-1:0]   pc_next
);

    logic signed [DISP_W-1:0] disp_s;
    logic [PC_W-1:0]          disp_sx;
    logic [PC_W-1:0]          pc_inc;

    // Size cast of a signed value sign-extends (or truncates when PC_W < DISP_W).
    assign disp_s  = disp;
    assign disp_sx = PC_W'(disp_s);
    assign pc_inc  = pc + PC_W'(1);
    assign pc_next = jump ? (pc_inc + disp_sx) : pc_inc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencer: owns the PC, fetches one instruction at a time from imem,
// strobes it to the decoder for one EXEC cycle and applies the decoder's branch decision.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    instr_fetch_unit_if.master imem,
    output logic [INS_W-1:0]  ins,
    output logic              ins_valid,
    input  logic              pcjumpselect,
    input  logic [DISP_W-1:0] disp,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            is_halt;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
        .pc      (pc),
        .jump    (pcjumpselect),
        .disp    (disp),
        .pc_next (pc_nxt)
    );

    assign is_halt = (opcode_of(ins) == OP_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // run is only sampled in IDLE and EXEC; a fetch already issued always runs to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (run) state_nxt = ST_FETCH;
            ST_FETCH: if (imem.valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (is_halt)  state_nxt = ST_HALT;
                else if (run) state_nxt = ST_FETCH;
                else          state_nxt = ST_IDLE;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so imem.req falls with an asynchronous reset.
    always_comb begin
        imem.req  = 1'b0;
        ins_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_FETCH: imem.req  = 1'b1;
            ST_EXEC:  ins_valid = 1'b1;
            ST_HALT:  halted    = 1'b1;
            default:  ;
        endcase
    end

    assign imem.addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= PC_W'(RESET_PC);
            ins <= '0;
        end else begin
            if (state == ST_FETCH && imem.valid) begin
                ins <= imem.rdata;
            end
            if (state == ST_EXEC && !is_halt) begin
                pc <= pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, branches, wrap, slow imem, halt, reset.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        pcjumpselect;
    logic [7:0]  disp;
    logic [15:0] ins;
    logic        ins_valid;
    logic [7:0]  pc;
    logic        halted;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_exec = -1;

    instr_fetch_unit_if #(.PC_W(8)) imem_bus ();

    instr_fetch_unit #(.PC_W(8), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem         (imem_bus),
        .ins          (ins),
        .ins_valid    (ins_valid),
        .pcjumpselect (pcjumpselect),
        .disp         (disp),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One instruction: wait for the request, answer after 'delay' cycles, drive the branch
    // inputs during EXEC. Called and returns on a falling edge.
    task automatic run_instr(input logic [7:0] addr, input logic [15:0] word, input int delay,
                             input logic jmp, input logic [7:0] d, input bit spurious,
                             input bit drop_run, input bit chk_period);
        int n = 0;
        while (!imem_bus.req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_seen", imem_bus.req, 1);
        if (!imem_bus.req) return;
        check_val("imem_addr", imem_bus.addr, addr);
        if (drop_run) run = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_val("req_hold", imem_bus.req, 1);
            check_val("addr_hold", imem_bus.addr, addr);
        end
        imem_bus.valid = 1'b1;
        imem_bus.rdata = word;
        @(negedge clk);
        imem_bus.valid = spurious;
        imem_bus.rdata = ~word;
        check_val("exec_ins_valid", ins_valid, 1);
        check_val("exec_ins", ins, word);
        check_val("exec_req", imem_bus.req, 0);
        check_val("exec_pc", pc, addr);
        if (chk_period && last_exec >= 0) check_val("period", cyc - last_exec, 3);
        last_exec = cyc;
        pcjumpselect = jmp;
        disp = d;
        @(negedge clk);
        imem_bus.valid = 1'b0;
        pcjumpselect = 1'b0;
        disp = 8'h00;
        check_val("ins_valid_drop", ins_valid, 0);
        check_val("ins_hold", ins, word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        pcjumpselect = 1'b0;
        disp = 8'h00;
        imem_bus.valid = 1'b0;
        imem_bus.rdata = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_req", imem_bus.req, 0);
        check_val("rst_pc", pc, 0);
        check_val("rst_ins", ins, 0);
        check_val("rst_ins_valid", ins_valid, 0);
        check_val("rst_halted", halted, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_no_run", imem_bus.req, 0);
        run = 1'b1;

        // sequential fetch, 3-cycle cadence
        run_instr(8'h00, 16'h0000, 1, 1'b0, 8'h00, 0, 0, 1);
        run_instr(8'h01, 16'h1000, 1, 1'b0, 8'h00, 0, 0, 1);
        run_instr(8'h02, 16'h2000, 1, 1'b0, 8'h00, 0, 0, 1);
        run_instr(8'h03, 16'h3000, 1, 1'b0, 8'h00, 0, 0, 1);
        run_instr(8'h04, 16'h5000, 1, 1'b0, 8'h00, 0, 0, 1);
        // branches: taken forward, taken back, not taken
        run_instr(8'h05, 16'h4003, 1, 1'b1, 8'h03, 0, 0, 1);
        run_instr(8'h09, 16'h4000, 1, 1'b1, 8'hFB, 0, 0, 1);
        run_instr(8'h05, 16'h4003, 1, 1'b0, 8'h03, 0, 0, 1);
        run_instr(8'h06, 16'h4000, 1, 1'b1, 8'hFB, 0, 0, 1);
        run_instr(8'h02, 16'h4000, 1, 1'b1, 8'hFE, 0, 0, 1);
        // wrap below zero, wrap above 0xFF, tight loop
        run_instr(8'h01, 16'h4000, 1, 1'b1, 8'hFD, 0, 0, 1);
        run_instr(8'hFF, 16'h1000, 1, 1'b0, 8'h00, 0, 0, 1);
        run_instr(8'h00, 16'h4000, 1, 1'b1, 8'hFF, 0, 0, 1);
        // slow imem plus spurious valid during EXEC
        run_instr(8'h00, 16'h2000, 4, 1'b0, 8'h00, 1, 0, 0);
        run_instr(8'h01, 16'h4000, 1, 1'b1, 8'h01, 0, 0, 0);
        // halt ignores branch inputs
        run_instr(8'h03, 16'hF000, 1, 1'b1, 8'h05, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check_val("halt_flag", halted, 1);
            check_val("halt_req", imem_bus.req, 0);
            check_val("halt_pc", pc, 3);
            @(negedge clk);
        end

        // reset out of HALT
        rst_n = 1'b0;
        #1;
        check_val("rst2_halted", halted, 0);
        check_val("rst2_pc", pc, 0);
        check_val("rst2_ins", ins, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(8'h00, 16'h5000, 1, 1'b0, 8'h00, 0, 0, 0);
        check_val("fetch1_req", imem_bus.req, 1);
        check_val("fetch1_addr", imem_bus.addr, 1);

        // reset in the middle of a fetch
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midfetch_req", imem_bus.req, 0);
        check_val("midfetch_pc", pc, 0);
        run = 1'b0;
        imem_bus.valid = 1'b1;
        imem_bus.rdata = 16'hABCD;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("idle_spur_req", imem_bus.req, 0);
        check_val("idle_spur_ins", ins, 0);
        check_val("idle_spur_pc", pc, 0);
        imem_bus.valid = 1'b0;

        // run dropped during FETCH: fetch completes, executes once, then IDLE
        run = 1'b1;
        run_instr(8'h00, 16'h1234, 2, 1'b0, 8'h00, 0, 1, 0);
        check_val("stop_req", imem_bus.req, 0);
        check_val("stop_pc", pc, 1);
        @(negedge clk);
        check_val("stop_req2", imem_bus.req, 0);
        check_val("stop_ins_valid", ins_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
